// File: rtl/apb_mailbox_slave_if.sv
// apb_mailbox_slave_if: APB3 completer bus bundle between the bridge and the mailbox
interface apb_mailbox_slave_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32
) ();
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mailbox_slave.sv
// apb_mailbox_slave: APB3 mailbox FIFO with control/status registers, wait states and threshold IRQ
module apb_mailbox_slave #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    apb_mailbox_slave_if.slave  apb,
    output logic                irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wp, rp;
    logic [CW-1:0]         count, thresh, count_nxt, thresh_nxt;
    logic [3:0]            wait_r, wcnt;
    logic                  access, done, mapped, empty, full, err;
    logic                  sel_data, sel_status, sel_ctrl, sel_thresh;
    logic                  push, pop, ctrl_wr, flush, thresh_wr;
    logic [DATA_WIDTH-1:0] status_rd, ctrl_rd, thresh_rd, reg_rd;
    logic                  unused_addr;
    assign unused_addr = ^apb.paddr[1:0];
    assign access      = apb.psel & apb.penable;
    assign apb.pready  = rst_ni & access & (wcnt == 4'd0);
    assign done        = apb.pready;
    assign mapped      = apb.paddr[11:4] == 8'd0;
    assign sel_data    = mapped & (apb.paddr[3:2] == 2'd0);
    assign sel_status  = mapped & (apb.paddr[3:2] == 2'd1);
    assign sel_ctrl    = mapped & (apb.paddr[3:2] == 2'd2);
    assign sel_thresh  = mapped & (apb.paddr[3:2] == 2'd3);
    assign empty       = count == '0;
    assign full        = count == CW'(FIFO_DEPTH);
    assign err         = !mapped | (sel_data & apb.pwrite & full) | (sel_data & !apb.pwrite & empty)
                       | (sel_status & apb.pwrite);
    assign apb.pslverr = done & err;
    assign push        = done & sel_data & apb.pwrite & !full;
    assign pop         = done & sel_data & !apb.pwrite & !empty;
    assign ctrl_wr     = done & sel_ctrl & apb.pwrite;
    assign flush       = ctrl_wr & apb.pwdata[0];
    assign thresh_wr   = done & sel_thresh & apb.pwrite;
    assign count_nxt   = flush ? '0 : push ? count + 1'b1 : pop ? count - 1'b1 : count;
    assign thresh_nxt  = thresh_wr ? apb.pwdata[CW-1:0] : thresh;
    // register read views; flush bit always reads back as zero
    always_comb begin
        status_rd          = '0;
        status_rd[0]       = empty;
        status_rd[1]       = full;
        status_rd[8 +: CW] = count;
        ctrl_rd            = '0;
        ctrl_rd[7:4]       = wait_r;
        thresh_rd          = '0;
        thresh_rd[CW-1:0]  = thresh;
        reg_rd             = sel_data ? mem[rp] : sel_status ? status_rd : sel_ctrl ? ctrl_rd : thresh_rd;
    end
    assign apb.prdata = (done & !err & !apb.pwrite) ? reg_rd : '0;
    // wait-state counter: load in setup, count down in access, hold if psel drops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wcnt <= '0;
        else if (apb.psel & !apb.penable) wcnt <= wait_r;
        else if (access && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end
    // FIFO bookkeeping, control registers and IRQ from post-update occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            thresh <= '0;
            wait_r <= '0;
            wp     <= '0;
            rp     <= '0;
            irq_o  <= 1'b0;
        end else begin
            count  <= count_nxt;
            thresh <= thresh_nxt;
            irq_o  <= (thresh_nxt != '0) && (count_nxt >= thresh_nxt);
            if (ctrl_wr) wait_r <= apb.pwdata[7:4];
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
            end
        end
    end
    // mailbox storage; contents are only observable while count is non-zero
    always_ff @(posedge clk_i) begin
        if (push) mem[wp] <= apb.pwdata;
    end
endmodule

// File: tb/tb_apb_mailbox_slave.sv
// tb_apb_mailbox_slave: directed table-driven and sequence checks for the APB mailbox
module tb_apb_mailbox_slave;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic irq;
    int   total = 0;
    int   passed = 0;
    apb_mailbox_slave_if #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
    apb_mailbox_slave #(.APB_ADDR_WIDTH(12), .DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .apb   (bus),
        .irq_o (irq)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        logic [3:0]  waits;
    } vec_t;
    vec_t v [14];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits, output logic rdy);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1'b1;
        waits = 0;
        #1;
        while (!bus.pready && waits < 40) begin
            @(negedge clk);
            #1;
            waits++;
        end
        rdy = bus.pready; rd = bus.prdata; err = bus.pslverr;
        @(posedge clk);
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask
    task automatic run(input string name, input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic err, rdy;
        int waits;
        xfer(w, a, d, rd, err, waits, rdy);
        check({name, " pready"}, {31'd0, rdy}, 32'd1);
        check({name, " prdata"}, rd, exp_rd);
        check({name, " pslverr"}, {31'd0, err}, {31'd0, exp_err});
        check({name, " waits"}, waits, exp_waits);
    endtask
    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        v[0]  = '{1'b1, 12'h000, 32'hA5A5_0001, 32'h0,         1'b0, 4'd0};
        v[1]  = '{1'b0, 12'h000, 32'h0,         32'hA5A5_0001, 1'b0, 4'd0};
        v[2]  = '{1'b0, 12'h004, 32'h0,         32'h1,         1'b0, 4'd0};
        v[3]  = '{1'b1, 12'h008, 32'h30,        32'h0,         1'b0, 4'd0};
        v[4]  = '{1'b0, 12'h004, 32'h0,         32'h1,         1'b0, 4'd3};
        v[5]  = '{1'b0, 12'h008, 32'h0,         32'h30,        1'b0, 4'd3};
        v[6]  = '{1'b1, 12'h008, 32'h0,         32'h0,         1'b0, 4'd3};
        v[7]  = '{1'b1, 12'h004, 32'h1234,      32'h0,         1'b1, 4'd0};
        v[8]  = '{1'b0, 12'h010, 32'h0,         32'h0,         1'b1, 4'd0};
        v[9]  = '{1'b0, 12'h100, 32'h0,         32'h0,         1'b1, 4'd0};
        v[10] = '{1'b1, 12'h010, 32'hFF,        32'h0,         1'b1, 4'd0};
        v[11] = '{1'b0, 12'h004, 32'h0,         32'h1,         1'b0, 4'd0};
        v[12] = '{1'b0, 12'h00C, 32'h0,         32'h0,         1'b0, 4'd0};
        v[13] = '{1'b0, 12'h000, 32'h0,         32'h0,         1'b1, 4'd0};
        #1;
        check("reset pready", {31'd0, bus.pready}, 32'd0);
        check("reset pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("reset prdata", bus.prdata, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        #22 rst_ni = 1'b1;
        for (int i = 0; i < 14; i++)
            run($sformatf("vec%0d", i), v[i].w, v[i].a, v[i].d, v[i].rd, v[i].err, int'(v[i].waits));
        for (int i = 1; i <= 8; i++) run($sformatf("push%0d", i), 1'b1, 12'h0, i, 32'h0, 1'b0, 0);
        run("push9 full", 1'b1, 12'h0, 32'h9, 32'h0, 1'b1, 0);
        run("status full", 1'b0, 12'h4, 32'h0, 32'h802, 1'b0, 0);
        for (int i = 1; i <= 8; i++) run($sformatf("pop%0d", i), 1'b0, 12'h0, 32'h0, i, 1'b0, 0);
        run("pop9 empty", 1'b0, 12'h0, 32'h0, 32'h0, 1'b1, 0);
        run("status empty", 1'b0, 12'h4, 32'h0, 32'h1, 1'b0, 0);
        run("thresh wr", 1'b1, 12'hC, 32'h3, 32'h0, 1'b0, 0);
        run("thresh rd", 1'b0, 12'hC, 32'h0, 32'h3, 1'b0, 0);
        run("irq push1", 1'b1, 12'h0, 32'h11, 32'h0, 1'b0, 0);
        run("irq push2", 1'b1, 12'h0, 32'h22, 32'h0, 1'b0, 0);
        check("irq below thresh", {31'd0, irq}, 32'd0);
        run("irq push3", 1'b1, 12'h0, 32'h33, 32'h0, 1'b0, 0);
        check("irq at thresh", {31'd0, irq}, 32'd1);
        run("irq pop", 1'b0, 12'h0, 32'h0, 32'h11, 1'b0, 0);
        check("irq after pop", {31'd0, irq}, 32'd0);
        run("irq push4", 1'b1, 12'h0, 32'h44, 32'h0, 1'b0, 0);
        check("irq refire", {31'd0, irq}, 32'd1);
        run("flush", 1'b1, 12'h8, 32'h1, 32'h0, 1'b0, 0);
        check("irq after flush", {31'd0, irq}, 32'd0);
        run("status flushed", 1'b0, 12'h4, 32'h0, 32'h1, 1'b0, 0);
        run("ctrl reads 0", 1'b0, 12'h8, 32'h0, 32'h0, 1'b0, 0);
        run("ctrl wait5", 1'b1, 12'h8, 32'h50, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++) run($sformatf("rst push%0d", i), 1'b1, 12'h0, 32'hC0 + i, 32'h0, 1'b0, 5);
        check("irq pre reset", {31'd0, irq}, 32'd1);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 12'h0;
        @(negedge clk);
        bus.penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("midrst pready", {31'd0, bus.pready}, 32'd0);
        check("midrst pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("midrst prdata", bus.prdata, 32'd0);
        check("midrst irq", {31'd0, irq}, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        run("post rst status", 1'b0, 12'h4, 32'h0, 32'h1, 1'b0, 0);
        run("post rst ctrl", 1'b0, 12'h8, 32'h0, 32'h0, 1'b0, 0);
        run("post rst thresh", 1'b0, 12'hC, 32'h0, 32'h0, 1'b0, 0);
        run("post rst pop", 1'b0, 12'h0, 32'h0, 32'h0, 1'b1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
